// File: rtl/aibcr3_dll_code_ctrl_if.sv
// Control, phase-detector and code signals between the DLL code controller and its environment.
// The master side drives the enables, detector pulses and load codes; the slave side drives the delay code and status.
interface aibcr3_dll_code_ctrl_if;
    logic       dll_en;
    logic       pd_up;
    logic       pd_dn;
    logic [6:0] init_code;
    logic       ovr_en;
    logic [6:0] ovr_code;
    logic [6:0] grey;
    logic [6:0] code_bin;
    logic       lock;
    logic [1:0] state;
    logic       at_min;
    logic       at_max;

    modport master (
        output dll_en, pd_up, pd_dn, init_code, ovr_en, ovr_code,
        input  grey, code_bin, lock, state, at_min, at_max
    );

    modport slave (
        input  dll_en, pd_up, pd_dn, init_code, ovr_en, ovr_code,
        output grey, code_bin, lock, state, at_min, at_max
    );
endinterface

// File: rtl/aibcr3_dll_code_ctrl.sv
// DLL delay-code controller: rate-limited, saturating up/down index with Gray-coded output, lock detection and override.
// All outputs are registered, so they change one clock after the inputs that cause them.
module aibcr3_dll_code_ctrl #(
    parameter int unsigned UPD_DIV    = 8,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_RUN = 4,
    parameter int unsigned MAX_IDX    = 64
) (
    input  logic                        CLKIN,
    input  logic                        RST,
    aibcr3_dll_code_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACQ   = 2'b01,
        S_TRACK = 2'b10,
        S_OVR   = 2'b11
    } state_t;

    localparam logic [6:0] MAX_CODE = 7'(MAX_IDX);
    localparam logic [3:0] DIV_LAST = 4'(UPD_DIV - 1);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_RUN);

    state_t     r_state, w_state;
    logic [6:0] r_code,  w_code;
    logic [6:0] r_grey,  w_grey;
    logic       r_lock,  w_lock;
    logic       r_at_min, r_at_max;
    logic [3:0] r_div,   w_div;
    logic [3:0] r_rev,   w_rev;
    logic [3:0] r_run,   w_run;
    logic       r_last_vld, w_last_vld;
    logic       r_last_up,  w_last_up;

    logic       w_tick;
    logic       w_step_up;
    logic       w_step_dn;
    logic       w_step;
    logic       w_rev_step;

    function automatic logic [6:0] f_clamp(input logic [6:0] v);
        return (v > MAX_CODE) ? MAX_CODE : v;
    endfunction

    // Saturated requests are dropped here so they behave exactly like a hold.
    assign w_tick     = (r_div == DIV_LAST);
    assign w_step_up  = w_tick && bus.pd_up && !bus.pd_dn && (r_code != MAX_CODE);
    assign w_step_dn  = w_tick && bus.pd_dn && !bus.pd_up && (r_code != 7'd0);
    assign w_step     = w_step_up || w_step_dn;
    assign w_rev_step = w_step && r_last_vld && (r_last_up != w_step_up);

    always_comb begin
        w_state    = r_state;
        w_code     = r_code;
        w_lock     = r_lock;
        w_div      = r_div;
        w_rev      = r_rev;
        w_run      = r_run;
        w_last_vld = r_last_vld;
        w_last_up  = r_last_up;

        if (!bus.dll_en) begin
            w_state = S_IDLE;
            w_lock  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_lock = 1'b0;
                    if (bus.ovr_en) begin
                        w_state = S_OVR;
                    end else begin
                        w_code     = f_clamp(bus.init_code);
                        w_div      = 4'd0;
                        w_rev      = 4'd0;
                        w_run      = 4'd0;
                        w_last_vld = 1'b0;
                        w_state    = S_ACQ;
                    end
                end
                S_ACQ, S_TRACK: begin
                    if (bus.ovr_en) begin
                        w_state = S_OVR;
                        w_code  = f_clamp(bus.ovr_code);
                        w_lock  = 1'b0;
                    end else begin
                        w_div = w_tick ? 4'd0 : r_div + 4'd1;
                        if (w_step) begin
                            w_code     = w_step_up ? r_code + 7'd1 : r_code - 7'd1;
                            w_last_vld = 1'b1;
                            w_last_up  = w_step_up;
                            if (r_state == S_ACQ) begin
                                if (w_rev_step) begin
                                    w_rev = r_rev + 4'd1;
                                    if (r_rev + 4'd1 == LOCK_N) begin
                                        w_state = S_TRACK;
                                        w_lock  = 1'b1;
                                        w_run   = 4'd1;
                                    end
                                end
                            end else if (w_rev_step) begin
                                w_run = 4'd1;
                            end else begin
                                w_run = r_run + 4'd1;
                                // A long one-sided run means the loop has lost phase.
                                if (r_run + 4'd1 == UNLOCK_N) begin
                                    w_state = S_ACQ;
                                    w_lock  = 1'b0;
                                    w_rev   = 4'd0;
                                    w_run   = 4'd0;
                                end
                            end
                        end
                    end
                end
                S_OVR: begin
                    w_lock = 1'b0;
                    if (bus.ovr_en) begin
                        w_code = f_clamp(bus.ovr_code);
                    end else begin
                        w_state    = S_ACQ;
                        w_div      = 4'd0;
                        w_rev      = 4'd0;
                        w_run      = 4'd0;
                        w_last_vld = 1'b0;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    assign w_grey = w_code ^ (w_code >> 1);

    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_code     <= 7'd0;
            r_grey     <= 7'd0;
            r_lock     <= 1'b0;
            r_at_min   <= 1'b1;
            r_at_max   <= 1'b0;
            r_div      <= 4'd0;
            r_rev      <= 4'd0;
            r_run      <= 4'd0;
            r_last_vld <= 1'b0;
            r_last_up  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_code     <= w_code;
            r_grey     <= w_grey;
            r_lock     <= w_lock;
            r_at_min   <= (w_code == 7'd0);
            r_at_max   <= (w_code == MAX_CODE);
            r_div      <= w_div;
            r_rev      <= w_rev;
            r_run      <= w_run;
            r_last_vld <= w_last_vld;
            r_last_up  <= w_last_up;
        end
    end

    assign bus.grey     = r_grey;
    assign bus.code_bin = r_code;
    assign bus.lock     = r_lock;
    assign bus.state    = r_state;
    assign bus.at_min   = r_at_min;
    assign bus.at_max   = r_at_max;

endmodule

// File: tb/tb_aibcr3_dll_code_ctrl.sv
// Directed bench for the DLL code controller; stimulus schedules expected outputs by cycle, a negedge monitor checks them.
module tb_aibcr3_dll_code_ctrl;

    typedef struct {
        int         tgt;
        string      nm;
        logic [6:0] code;
        logic [6:0] grey;
        logic       lock;
        logic [1:0] st;
    } exp_t;

    logic CLKIN;
    logic RST;
    int   cyc;
    int   n_chk;
    int   n_fail;
    bit   done;
    exp_t sb[$];
    exp_t mon_e;

    aibcr3_dll_code_ctrl_if dut_if ();

    aibcr3_dll_code_ctrl #(
        .UPD_DIV   (8),
        .LOCK_CNT  (4),
        .UNLOCK_RUN(4),
        .MAX_IDX   (64)
    ) u_dut (
        .CLKIN(CLKIN),
        .RST  (RST),
        .bus  (dut_if)
    );

    initial CLKIN = 1'b0;
    always #5 CLKIN = ~CLKIN;

    initial cyc = 0;
    always @(posedge CLKIN) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step_clk(input int n);
        repeat (n) @(posedge CLKIN);
        #1;
    endtask

    task automatic push(input int tgt, input string nm, input logic [6:0] c,
                        input logic [6:0] g, input logic l, input logic [1:0] s);
        exp_t e;
        e.tgt  = tgt;
        e.nm   = nm;
        e.code = c;
        e.grey = g;
        e.lock = l;
        e.st   = s;
        sb.push_back(e);
    endtask

    task automatic set_pd(input int p);
        dut_if.pd_up = (p == 1) || (p == 3);
        dut_if.pd_dn = (p == 2) || (p == 3);
    endtask

    // Monitor: compares every scheduled expectation whose cycle has come; once stimulus ends, unreached ones fail.
    initial begin
        n_chk  = 0;
        n_fail = 0;
    end

    always @(negedge CLKIN) begin
        while (sb.size() > 0 && (done || sb[0].tgt <= cyc)) begin
            mon_e = sb.pop_front();
            n_chk++;
            if (mon_e.tgt != cyc) begin
                n_fail++;
                $display("FAIL %s: scheduled for cycle %0d, evaluated at cycle %0d", mon_e.nm, mon_e.tgt, cyc);
            end else if (dut_if.code_bin !== mon_e.code || dut_if.grey !== mon_e.grey ||
                         dut_if.lock !== mon_e.lock || dut_if.state !== mon_e.st ||
                         dut_if.at_min !== (mon_e.code == 7'd0) || dut_if.at_max !== (mon_e.code == 7'd64)) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got code=%0d grey=%b lock=%b state=%b min=%b max=%b; expected code=%0d grey=%b lock=%b state=%b min=%b max=%b",
                         mon_e.nm, cyc, dut_if.code_bin, dut_if.grey, dut_if.lock, dut_if.state,
                         dut_if.at_min, dut_if.at_max, mon_e.code, mon_e.grey, mon_e.lock, mon_e.st,
                         (mon_e.code == 7'd0), (mon_e.code == 7'd64));
            end
        end
    end

    int pat [14] = '{2, 1, 2, 1, 2, 1, 1, 1, 1, 2, 1, 3, 2, 1};
    int e0;

    initial begin
        done             = 1'b0;
        RST              = 1'b1;
        dut_if.dll_en    = 1'b0;
        dut_if.pd_up     = 1'b0;
        dut_if.pd_dn     = 1'b0;
        dut_if.init_code = 7'd0;
        dut_if.ovr_en    = 1'b0;
        dut_if.ovr_code  = 7'd0;

        // Reset values, then idle hold with dll_en low.
        step_clk(2);
        push(cyc, "reset", 7'd0, 7'b0000000, 1'b0, 2'b00);
        RST = 1'b0;
        push(cyc + 10, "idle_hold", 7'd0, 7'b0000000, 1'b0, 2'b00);
        step_clk(10);

        // Load 20, step up once every 8 cycles.
        dut_if.init_code = 7'd20;
        dut_if.pd_up     = 1'b1;
        dut_if.dll_en    = 1'b1;
        step_clk(1);
        push(cyc,      "load20",   7'd20, 7'b0011110, 1'b0, 2'b01);
        push(cyc + 7,  "pre_tick", 7'd20, 7'b0011110, 1'b0, 2'b01);
        push(cyc + 8,  "tick1_21", 7'd21, 7'b0011111, 1'b0, 2'b01);
        push(cyc + 16, "tick2_22", 7'd22, 7'b0011101, 1'b0, 2'b01);
        step_clk(16);
        dut_if.dll_en = 1'b0;
        step_clk(1);
        push(cyc, "disable_hold", 7'd22, 7'b0011101, 1'b0, 2'b00);

        // Up saturation from 63, then down saturation from 1.
        dut_if.init_code = 7'd63;
        dut_if.dll_en    = 1'b1;
        step_clk(1);
        push(cyc,      "load63",  7'd63, 7'b0100000, 1'b0, 2'b01);
        push(cyc + 8,  "max64",   7'd64, 7'b1100000, 1'b0, 2'b01);
        push(cyc + 24, "max_sat", 7'd64, 7'b1100000, 1'b0, 2'b01);
        step_clk(24);
        dut_if.dll_en = 1'b0;
        step_clk(1);
        dut_if.init_code = 7'd1;
        set_pd(2);
        dut_if.dll_en = 1'b1;
        step_clk(1);
        push(cyc,      "load1",   7'd1, 7'b0000001, 1'b0, 2'b01);
        push(cyc + 8,  "min0",    7'd0, 7'b0000000, 1'b0, 2'b01);
        push(cyc + 24, "min_sat", 7'd0, 7'b0000000, 1'b0, 2'b01);
        step_clk(24);
        dut_if.dll_en = 1'b0;
        step_clk(1);

        // Lock on alternating steps, unlock on an up-run, re-lock with a both-high hold in between.
        dut_if.init_code = 7'd30;
        dut_if.dll_en    = 1'b1;
        step_clk(1);
        e0 = cyc;
        push(e0,       "load30",      7'd30, 7'b0010001, 1'b0, 2'b01);
        push(e0 + 32,  "pre_lock",    7'd30, 7'b0010001, 1'b0, 2'b01);
        push(e0 + 40,  "lock_5th",    7'd29, 7'b0010011, 1'b1, 2'b10);
        push(e0 + 64,  "run3_locked", 7'd32, 7'b0110000, 1'b1, 2'b10);
        push(e0 + 72,  "run4_unlock", 7'd33, 7'b0110001, 1'b0, 2'b01);
        push(e0 + 96,  "both_hold",   7'd33, 7'b0110001, 1'b0, 2'b01);
        push(e0 + 104, "no_rev_hold", 7'd32, 7'b0110000, 1'b0, 2'b01);
        push(e0 + 112, "relock",      7'd33, 7'b0110001, 1'b1, 2'b10);
        for (int k = 0; k < 14; k++) begin
            set_pd(pat[k]);
            step_clk(8);
        end

        // Override from TRACK with a clamped code, then release back to ACQ.
        dut_if.ovr_code = 7'd100;
        dut_if.ovr_en   = 1'b1;
        step_clk(1);
        push(cyc,     "ovr_entry", 7'd64, 7'b1100000, 1'b0, 2'b11);
        push(cyc + 3, "ovr_hold",  7'd64, 7'b1100000, 1'b0, 2'b11);
        step_clk(3);
        set_pd(2);
        dut_if.ovr_en = 1'b0;
        step_clk(1);
        push(cyc,     "ovr_exit",     7'd64, 7'b1100000, 1'b0, 2'b01);
        push(cyc + 7, "ovr_pre_tick", 7'd64, 7'b1100000, 1'b0, 2'b01);
        push(cyc + 8, "ovr_tick",     7'd63, 7'b0100000, 1'b0, 2'b01);
        step_clk(10);

        // Asynchronous reset in ACQ, asserted between clock edges.
        #2;
        RST           = 1'b1;
        dut_if.dll_en = 1'b0;
        push(cyc, "async_rst", 7'd0, 7'b0000000, 1'b0, 2'b00);
        step_clk(1);
        push(cyc, "rst_held", 7'd0, 7'b0000000, 1'b0, 2'b00);
        RST = 1'b0;
        step_clk(2);

        done = 1'b1;
        step_clk(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
